// File: rtl/gift_dispatcher.sv
// Dispatches queued brick-destroyed spawn positions to free gift slots, round-robin,
// holding the granted slot's load-enable for a bounded window until it goes active.
module gift_dispatcher #(
   parameter int NSLOT  = 4,
   parameter int SBIT   = 2,
   parameter int DEPTH  = 4,
   parameter int DBIT   = 2,
   parameter int WINDOW = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [9:0]       req_x,
   input  logic [9:0]       req_y,
   output logic             req_ready,
   input  logic             freeze,
   input  logic [NSLOT-1:0] slot_active,
   output logic [NSLOT-1:0] slot_enable,
   output logic [9:0]       slot_x,
   output logic [9:0]       slot_y,
   output logic [SBIT-1:0]  grant_idx,
   output logic             spawn_pulse,
   output logic             miss_pulse,
   output logic [7:0]       drop_count,
   output logic             overflow,
   output logic             state_dbg
);

   localparam int CBIT = DBIT + 1;
   localparam int TBIT = $clog2(WINDOW + 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           state_q, state_d;
   logic [DBIT-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CBIT-1:0]  count_q, count_d;
   logic [19:0]      fifo_q [DEPTH];
   logic [TBIT-1:0]  timer_q, timer_d;
   logic [SBIT-1:0]  grant_q, grant_d, ptr_q, ptr_d;
   logic [9:0]       x_q, x_d, y_q, y_d;
   logic             spawn_q, spawn_d, miss_q, miss_d, overflow_q, overflow_d;
   logic [7:0]       drops_q, drops_d;
   logic             push, pop, free_found;
   logic [SBIT-1:0]  free_idx, cand;
   logic [19:0]      head;

   // Ready is derived from the registered count only, so a full FIFO rejects
   // a push even in a cycle that also pops.
   assign req_ready = (count_q != CBIT'(DEPTH));
   assign push      = req_valid && req_ready;
   assign head      = fifo_q[rd_ptr_q];

   always_comb begin
      free_found = 1'b0;
      free_idx   = ptr_q;
      cand       = '0;
      for (int i = 1; i <= NSLOT; i++) begin
         cand = ptr_q + SBIT'(i);
         if (!free_found && !slot_active[cand]) begin
            free_found = 1'b1;
            free_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      x_d         = x_q;
      y_d         = y_q;
      drops_d     = drops_q;
      spawn_d     = 1'b0;
      miss_d      = 1'b0;
      pop         = 1'b0;
      slot_enable = '0;
      case (state_q)
         S_IDLE: begin
            if ((count_q != '0) && !freeze && free_found) begin
               grant_d = free_idx;
               ptr_d   = free_idx;
               x_d     = head[19:10];
               y_d     = head[9:0];
               timer_d = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!freeze) slot_enable = NSLOT'(1) << grant_q;
            // A spawn takes priority over window expiry on the same edge.
            if (slot_active[grant_q]) begin
               pop     = 1'b1;
               spawn_d = 1'b1;
               if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
               state_d = S_IDLE;
            end else if (!freeze) begin
               if (timer_q == TBIT'(WINDOW - 1)) begin
                  pop     = 1'b1;
                  miss_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d = overflow_q | (req_valid & ~req_ready);
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         timer_q    <= '0;
         grant_q    <= '0;
         ptr_q      <= SBIT'(NSLOT - 1);
         x_q        <= '0;
         y_q        <= '0;
         spawn_q    <= 1'b0;
         miss_q     <= 1'b0;
         drops_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         spawn_q    <= spawn_d;
         miss_q     <= miss_d;
         drops_q    <= drops_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_q[wr_ptr_q] <= {req_x, req_y};
   end

   assign slot_x      = x_q;
   assign slot_y      = y_q;
   assign grant_idx   = grant_q;
   assign spawn_pulse = spawn_q;
   assign miss_pulse  = miss_q;
   assign drop_count  = drops_q;
   assign overflow    = overflow_q;
   assign state_dbg   = (state_q == S_WAIT);

endmodule

// File: tb/tb_gift_dispatcher.sv
// Bench for gift_dispatcher: directed scenarios with literal expectations, then
// randomized traffic against a queue-based reference model of the dispatcher.
module tb_gift_dispatcher;

   localparam int NSLOT = 4;
   localparam int DEPTH = 4;
   localparam int WINDOW = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid = 1'b0;
   logic [9:0] req_x = '0, req_y = '0;
   logic       req_ready;
   logic       freeze = 1'b0;
   logic [3:0] slot_active = '0;
   logic [3:0] slot_enable;
   logic [9:0] slot_x, slot_y;
   logic [1:0] grant_idx;
   logic       spawn_pulse, miss_pulse, overflow, state_dbg;
   logic [7:0] drop_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   int mq_x[$];
   int mq_y[$];
   bit m_busy, m_spawn, m_miss, m_ovf;
   int m_gidx, m_ptr, m_left, m_x, m_y, m_drops;

   gift_dispatcher dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
      .req_ready(req_ready), .freeze(freeze), .slot_active(slot_active),
      .slot_enable(slot_enable), .slot_x(slot_x), .slot_y(slot_y), .grant_idx(grant_idx),
      .spawn_pulse(spawn_pulse), .miss_pulse(miss_pulse), .drop_count(drop_count),
      .overflow(overflow), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      mq_x.delete(); mq_y.delete();
      m_busy = 0; m_spawn = 0; m_miss = 0; m_ovf = 0;
      m_gidx = 0; m_ptr = NSLOT - 1; m_left = 0; m_x = 0; m_y = 0; m_drops = 0;
   endtask

   // Advance the model across one edge with the current inputs, then the DUT.
   task automatic step();
      bit rdy, pop;
      int k;
      rdy = (mq_x.size() < DEPTH);
      pop = 0; m_spawn = 0; m_miss = 0;
      if (m_busy) begin
         if (slot_active[m_gidx]) begin
            m_spawn = 1; pop = 1; m_busy = 0;
            if (m_drops < 255) m_drops++;
         end else if (!freeze) begin
            m_left--;
            if (m_left == 0) begin m_miss = 1; pop = 1; m_busy = 0; end
         end
      end else if (mq_x.size() > 0 && !freeze) begin
         for (int i = 1; i <= NSLOT; i++) begin
            k = (m_ptr + i) % NSLOT;
            if (!slot_active[k]) begin
               m_busy = 1; m_gidx = k; m_ptr = k; m_x = mq_x[0]; m_y = mq_y[0]; m_left = WINDOW;
               break;
            end
         end
      end
      if (pop) begin void'(mq_x.pop_front()); void'(mq_y.pop_front()); end
      if (req_valid) begin
         if (rdy) begin mq_x.push_back(int'(req_x)); mq_y.push_back(int'(req_y)); end
         else m_ovf = 1;
      end
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 0; req_valid = 0; freeze = 0; slot_active = '0;
      model_reset();
      @(posedge clock); @(posedge clock); #1;
      reset = 1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", req_ready); end
      checks++; if (slot_enable !== 4'b0) begin errors++; $display("FAIL rst_enable got %b exp 0000", slot_enable); end
      checks++; if (slot_x !== 10'd0 || slot_y !== 10'd0) begin errors++; $display("FAIL rst_xy got %0d,%0d exp 0,0", slot_x, slot_y); end
      checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d exp 0", grant_idx); end
      checks++; if ({spawn_pulse, miss_pulse, overflow} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {spawn_pulse, miss_pulse, overflow}); end
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_drops got %0d exp 0", drop_count); end
   endtask

   task automatic test_single_spawn();
      int n;
      do_reset();
      req_valid = 1; req_x = 10'd100; req_y = 10'd40;
      step();
      req_valid = 0;
      checks++; if (slot_enable !== 4'b0) begin errors++; $display("FAIL ss_early_enable got %b exp 0000", slot_enable); end
      step();
      checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL ss_grant got %0d exp 0", grant_idx); end
      checks++; if (slot_x !== 10'd100 || slot_y !== 10'd40) begin errors++; $display("FAIL ss_xy got %0d,%0d exp 100,40", slot_x, slot_y); end
      n = 0;
      for (int c = 0; c < 3; c++) begin
         if (slot_enable === 4'b0001) n++;
         if (c == 2) slot_active = 4'b0001;
         if (c < 2) step();
      end
      checks++; if (n != 3) begin errors++; $display("FAIL ss_enable_cycles got %0d exp 3", n); end
      step();
      checks++; if (slot_enable !== 4'b0) begin errors++; $display("FAIL ss_enable_drop got %b exp 0000", slot_enable); end
      checks++; if (spawn_pulse !== 1'b1) begin errors++; $display("FAIL ss_spawn got %0b exp 1", spawn_pulse); end
      checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ss_drops got %0d exp 1", drop_count); end
      slot_active = 4'b0000;
      step();
      checks++; if (spawn_pulse !== 1'b0) begin errors++; $display("FAIL ss_spawn_once got %0b exp 0", spawn_pulse); end
      checks++; if (slot_x !== 10'd100) begin errors++; $display("FAIL ss_x_hold got %0d exp 100", slot_x); end
   endtask

   task automatic test_overflow();
      do_reset();
      slot_active = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1; req_x = 10'(10 * i + 1); req_y = 10'(10 * i + 2);
         step();
         checks++; if (req_ready !== (i < 3 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL of_ready%0d got %0b exp %0b", i, req_ready, (i < 3)); end
         checks++; if (slot_enable !== 4'b0) begin errors++; $display("FAIL of_enable%0d got %b exp 0000", i, slot_enable); end
      end
      req_valid = 0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL of_sticky got %0b exp 1", overflow); end
      step();
      slot_active = 4'b1011;
      step();
      checks++; if (grant_idx !== 2'd2 || slot_enable !== 4'b0100) begin errors++; $display("FAIL of_grant got %0d/%b exp 2/0100", grant_idx, slot_enable); end
      checks++; if (slot_x !== 10'd1 || slot_y !== 10'd2) begin errors++; $display("FAIL of_xy got %0d,%0d exp 1,2", slot_x, slot_y); end
      slot_active = 4'b1111;
      step();
      checks++; if (spawn_pulse !== 1'b1 || req_ready !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL of_pop got spawn%0b ready%0b ovf%0b exp 111", spawn_pulse, req_ready, overflow); end
   endtask

   task automatic test_miss();
      int n;
      bit seen;
      do_reset();
      n = 0; seen = 0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1; req_x = 10'(200 + i); req_y = 10'(300 + i);
         if (slot_enable === 4'b0001) n++;
         step();
      end
      req_valid = 0;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL miss_full got %0b exp 0", req_ready); end
      for (int c = 0; c < 40 && !seen; c++) begin
         if (slot_enable === 4'b0001) n++;
         step();
         if (miss_pulse === 1'b1) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL miss_pulse got none exp 1 within 40 cycles"); end
      checks++; if (n != WINDOW) begin errors++; $display("FAIL miss_window got %0d exp %0d", n, WINDOW); end
      checks++; if (req_ready !== 1'b1 || drop_count !== 8'd0) begin errors++; $display("FAIL miss_pop got ready%0b drops%0d exp ready1 drops0", req_ready, drop_count); end
      step();
      checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL miss_once got %0b exp 0", miss_pulse); end
      checks++; if (grant_idx !== 2'd1 || slot_x !== 10'd201) begin errors++; $display("FAIL miss_next got %0d/%0d exp 1/201", grant_idx, slot_x); end
   endtask

   task automatic test_round_robin();
      bit got;
      int exp_g;
      do_reset();
      for (int r = 0; r < 5; r++) begin
         exp_g = r % NSLOT;
         req_valid = 1; req_x = 10'(r); req_y = 10'(r + 50);
         step();
         req_valid = 0;
         got = 0;
         for (int t = 0; t < 8 && !got; t++) begin
            if (slot_enable !== 4'b0) got = 1;
            else step();
         end
         checks++; if (!got || grant_idx !== 2'(exp_g) || slot_enable !== 4'(1 << exp_g)) begin
            errors++; $display("FAIL rr_grant%0d got %0d/%b exp %0d", r, grant_idx, slot_enable, exp_g); end
         slot_active = 4'(1 << exp_g);
         step();
         checks++; if (spawn_pulse !== 1'b1) begin errors++; $display("FAIL rr_spawn%0d got %0b exp 1", r, spawn_pulse); end
         slot_active = 4'b0;
         step();
      end
      checks++; if (drop_count !== 8'd5) begin errors++; $display("FAIL rr_drops got %0d exp 5", drop_count); end
   endtask

   task automatic test_freeze();
      int n;
      bit seen;
      do_reset();
      req_valid = 1; req_x = 10'd7; req_y = 10'd9;
      step();
      req_valid = 0;
      step();
      repeat (7) step();
      freeze = 1; #1;
      checks++; if (slot_enable !== 4'b0) begin errors++; $display("FAIL frz_enable got %b exp 0000", slot_enable); end
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (slot_enable !== 4'b0 || miss_pulse !== 1'b0) begin errors++; $display("FAIL frz_hold%0d got %b/%0b exp 0000/0", c, slot_enable, miss_pulse); end
      end
      freeze = 0; #1;
      n = 0; seen = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
         if (slot_enable === 4'b0001) n++;
         step();
         if (miss_pulse === 1'b1) seen = 1;
      end
      checks++; if (!seen || n != 9) begin errors++; $display("FAIL frz_resume got %0d cycles seen%0b exp 9 seen1", n, seen); end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req_valid = 1; req_x = 10'(400 + i); req_y = 10'(500 + i);
         step();
      end
      req_valid = 0;
      step();
      reset = 0; #1;
      checks++; if (req_ready !== 1'b1 || slot_enable !== 4'b0 || overflow !== 1'b0) begin
         errors++; $display("FAIL mr_async got ready%0b en%b ovf%0b exp 1/0000/0", req_ready, slot_enable, overflow); end
      checks++; if (slot_x !== 10'd0 || grant_idx !== 2'd0 || drop_count !== 8'd0) begin
         errors++; $display("FAIL mr_regs got x%0d g%0d d%0d exp 0/0/0", slot_x, grant_idx, drop_count); end
      model_reset();
      @(posedge clock); #1;
      reset = 1;
      for (int c = 0; c < 20; c++) begin
         step();
         checks++; if (spawn_pulse !== 1'b0 || miss_pulse !== 1'b0 || slot_enable !== 4'b0) begin
            errors++; $display("FAIL mr_quiet%0d got s%0b m%0b en%b exp 0/0/0000", c, spawn_pulse, miss_pulse, slot_enable); end
      end
   endtask

   task automatic test_random();
      logic [3:0] exp_en;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         req_valid = ($urandom_range(0, 9) < 3);
         req_x = 10'($urandom); req_y = 10'($urandom);
         freeze = ($urandom_range(0, 9) == 0);
         for (int s = 0; s < NSLOT; s++) slot_active[s] = ($urandom_range(0, 7) == 0);
         step();
         exp_en = (m_busy && !freeze) ? 4'(1 << m_gidx) : 4'b0;
         checks++; if (req_ready !== (mq_x.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d got %0b exp %0b", c, req_ready, (mq_x.size() < DEPTH)); end
         checks++; if (slot_enable !== exp_en) begin errors++; $display("FAIL rnd_enable c%0d got %b exp %b", c, slot_enable, exp_en); end
         checks++; if (slot_x !== 10'(m_x) || slot_y !== 10'(m_y)) begin errors++; $display("FAIL rnd_xy c%0d got %0d,%0d exp %0d,%0d", c, slot_x, slot_y, m_x, m_y); end
         checks++; if (grant_idx !== 2'(m_gidx)) begin errors++; $display("FAIL rnd_grant c%0d got %0d exp %0d", c, grant_idx, m_gidx); end
         checks++; if (spawn_pulse !== m_spawn || miss_pulse !== m_miss) begin errors++; $display("FAIL rnd_pulses c%0d got %0b%0b exp %0b%0b", c, spawn_pulse, miss_pulse, m_spawn, m_miss); end
         checks++; if (drop_count !== 8'(m_drops) || overflow !== m_ovf) begin errors++; $display("FAIL rnd_counts c%0d got %0d/%0b exp %0d/%0b", c, drop_count, overflow, m_drops, m_ovf); end
      end
      freeze = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_spawn();
      test_overflow();
      test_miss();
      test_round_robin();
      test_freeze();
      test_reset_mid_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gift_dispatcher.md
Name: gift_dispatcher

Overview:
- Shares a fixed pool of falling-gift slots between brick-destroyed events from the block field.
- Queues each event's spawn position (x, y) in a small FIFO.
- Picks a free slot round-robin and holds that slot's load-enable for a bounded window. Each slot's own random gate decides whether a gift actually appears in that window.
- Sits between the brick collision logic and the array of gift slot instances. It drives their enable and shared position inputs and watches their active flags.

Parameters:
- NSLOT, 4: number of gift slots; power of two, 2..8.
- SBIT, 2: log2(NSLOT); width of the slot index.
- DEPTH, 4: request FIFO entries; power of two.
- DBIT, 2: log2(DEPTH).
- WINDOW, 16: number of enabled cycles one request may wait for its slot to go active.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- req_valid  in  1  brick-destroyed event; held with req_x/req_y for one cycle.
- req_x  in  10  spawn x of the event.
- req_y  in  10  spawn y of the event.
- req_ready  out  1  FIFO can accept a request this cycle.
- freeze  in  1  game paused; stop dispatching and hold the window timer.
- slot_active  in  NSLOT  active flag of each gift slot.
- slot_enable  out  NSLOT  one-hot load-enable to the granted slot; zero when not granting.
- slot_x  out  10  shared spawn x bus to all slots.
- slot_y  out  10  shared spawn y bus to all slots.
- grant_idx  out  SBIT  index of the current or most recent granted slot.
- spawn_pulse  out  1  one-cycle pulse: the granted slot went active.
- miss_pulse  out  1  one-cycle pulse: the window expired without a spawn.
- drop_count  out  8  gifts spawned since reset; saturates at 255.
- overflow  out  1  sticky; set by req_valid while req_ready=0.

Behaviour:
- Reset values:
  - FIFO empty; req_ready=1.
  - slot_enable=0; slot_x=0; slot_y=0.
  - grant_idx=0; round-robin pointer=NSLOT-1, so the first grant goes to slot 0.
  - spawn_pulse=0; miss_pulse=0; drop_count=0; overflow=0; state IDLE.
  - Reset mid-operation discards queued requests and any open window.
- FIFO:
  - Push on req_valid && req_ready.
  - req_ready = !full, from the registered count only. When full, a push is rejected even if a pop occurs in the same cycle.
  - A rejected push sets overflow; overflow clears only on reset.
  - Pop happens only on leaving WAIT. Simultaneous push and pop when not full leaves the count unchanged.
- Slot selection:
  - Scan from pointer+1 upward, modulo NSLOT, for the first k with slot_active[k]=0.
  - If no slot is free, stay in IDLE; the request keeps waiting in the FIFO.
- FSM IDLE:
  - Transition when the FIFO is non-empty, freeze=0 and a free slot exists.
  - On that edge: grant_idx=k, pointer=k, slot_x/slot_y=FIFO head, timer=0, go to WAIT.
- FSM WAIT:
  - slot_enable = (1<<grant_idx) whenever freeze=0; 0 while freeze=1.
  - The timer increments on each cycle with enable asserted. It holds while frozen.
  - If slot_active[grant_idx]=1 at an edge: pop, drop_count+1 (saturating), spawn_pulse for the next cycle, go to IDLE. slot_enable drops that same edge.
  - Else if the timer reaches WINDOW-1 on an enabled edge: pop, miss_pulse for the next cycle, go to IDLE.
  - Active wins if both happen on the same edge.
- Latency: a request accepted at edge N into an empty FIFO, with IDLE state and slot 0 free, gives grant at edge N+1. slot_enable[0] is high from edge N+1 through the spawn/miss edge.
- Back-to-back requests: IDLE lasts at least one cycle between grants.
- Other slots becoming active or inactive during WAIT have no effect.
- slot_x and slot_y stay stable for the whole WAIT state. They keep their value after it ends.

Test Plan:
- Reset release, one request (x=100, y=40), slot_active=0000, slot_active[0] tied to rise on the 3rd enable cycle -> grant_idx=0, slot_enable=0001 for 3 cycles, slot_x=100, slot_y=40, spawn_pulse once, drop_count=1.
- Five requests on consecutive cycles, all slots busy (1111) -> req_ready=0 after the 4th push, overflow=1, no slot_enable; release slot 2 -> grant_idx=2 with the 1st queued position.
- Slot never goes active -> slot_enable held exactly 16 cycles, miss_pulse once, drop_count unchanged, FIFO count decreases by 1.
- Round-robin: four requests, all slots free, each spawning after 1 cycle -> grants 0,1,2,3, then 0 again on the 5th request.
- freeze asserted for 5 cycles at WAIT timer=7 -> slot_enable=0 and timer held; the miss occurs after 9 more enabled cycles.
- reset pulled low mid-WAIT with 3 queued requests -> all outputs at reset values immediately; req_ready=1; no spawn/miss pulse after release.
